// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_gen_if
// Brief   : Pixel-stream handshake and window/result bus of the 5x5 window generator.
// Revision: 1.0
// ============================================================================
interface conv_window_gen_if #(
  parameter int DATA_W = 8
);
  logic signed [DATA_W-1:0]            pix_in;
  logic                                pix_valid;
  logic                                pix_ready;
  logic signed [4:0][4:0][DATA_W-1:0]  win;
  logic                                win_valid;
  logic                                res_valid;
  logic                                res_last;
  logic                                frame_done;

  modport master (
    output pix_in, pix_valid,
    input  pix_ready, win, win_valid, res_valid, res_last, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output pix_ready, win, win_valid, res_valid, res_last, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_gen
// Brief   : 4 line buffers + 5x5 window feeding the conv datapath; regenerates
//           result-valid / end-of-frame markers after the datapath latency.
// Revision: 1.0
// ============================================================================
module conv_window_gen #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int DATA_W   = 8,
  parameter int CONV_LAT = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  conv_window_gen_if.slave  cw_io
);

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = $clog2(IMG_H);

  localparam logic [0:0] c_st_fill  = 1'b0;
  localparam logic [0:0] c_st_drain = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic                        ready_q;
  logic [c_col_w-1:0]          col_q, col_d;
  logic [c_row_w-1:0]          row_q, row_d;
  logic                        win_valid_q, win_valid_d;
  logic                        win_last_q, win_last_d;
  logic [CONV_LAT-1:0]         vld_dly_q;
  logic [CONV_LAT-1:0]         last_dly_q;
  logic [DATA_W-1:0]           lb_q [4][IMG_W];
  logic [4:0][4:0][DATA_W-1:0] win_q;

  logic w_xfer;
  logic w_col_end;
  logic w_last_pix;
  logic w_res_last;

  assign w_xfer     = cw_io.pix_valid & ready_q;
  assign w_col_end  = (col_q == c_col_w'(IMG_W - 1));
  assign w_last_pix = w_col_end && (row_q == c_row_w'(IMG_H - 1));
  assign w_res_last = vld_dly_q[CONV_LAT-1] & last_dly_q[CONV_LAT-1];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    case (state_q)
      c_st_fill: begin
        if (w_xfer) begin
          win_valid_d = (row_q >= c_row_w'(4)) && (col_q >= c_col_w'(4));
          win_last_d  = w_last_pix;
          if (w_last_pix) begin
            state_d = c_st_drain;
            col_d   = '0;
            row_d   = '0;
          end else if (w_col_end) begin
            col_d = '0;
            row_d = row_q + c_row_w'(1);
          end else begin
            col_d = col_q + c_col_w'(1);
          end
        end
      end
      c_st_drain: begin
        // Input stays closed until the frame's final result has left the datapath.
        if (w_res_last) state_d = c_st_fill;
      end
      default: state_d = c_st_fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_st_fill;
      ready_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      vld_dly_q   <= '0;
      last_dly_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == c_st_fill);
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      vld_dly_q   <= CONV_LAT'({vld_dly_q, win_valid_q});
      last_dly_q  <= CONV_LAT'({last_dly_q, win_last_q});
    end
  end

  // Window and line buffers carry no reset; win_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
      end
      win_q[0][4] <= lb_q[3][col_q];
      win_q[1][4] <= lb_q[2][col_q];
      win_q[2][4] <= lb_q[1][col_q];
      win_q[3][4] <= lb_q[0][col_q];
      win_q[4][4] <= cw_io.pix_in;
      lb_q[0][col_q] <= cw_io.pix_in;
      for (int k = 0; k < 3; k++) begin
        lb_q[k+1][col_q] <= lb_q[k][col_q];
      end
    end
  end

  assign cw_io.pix_ready  = ready_q;
  assign cw_io.win        = win_q;
  assign cw_io.win_valid  = win_valid_q;
  assign cw_io.res_valid  = vld_dly_q[CONV_LAT-1];
  assign cw_io.res_last   = w_res_last;
  assign cw_io.frame_done = w_res_last;

endmodule
`default_nettype wire
